axis_pattern_generator: RTL

- Parametrised AXI4-Stream master source; successor to the fixed-width free-running generator.
- Emits packets of configurable length with selectable data pattern: counter, LFSR, constant, walking-one.
- tlast marks packet boundaries; full AXI-Stream backpressure compliance.
- Sits at the stream source of lab datapaths; feeds FIFOs and checkers under test.

---
 rtl/gen_pkg.sv | 20 ++
 rtl/gen_pattern_next.sv | 26 ++
 rtl/axis_pattern_generator.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/gen_pkg.sv
// Shared encodings for the AXI4-Stream pattern generator: pattern modes, FSM states
// and the default Galois LFSR feedback mask.
package gen_pkg;

   typedef enum logic [1:0] {
      MODE_COUNTER = 2'd0,
      MODE_LFSR    = 2'd1,
      MODE_CONST   = 2'd2,
      MODE_WALK    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2
   } state_e;

   localparam logic [31:0] LFSR_TAPS_DEFAULT = 32'h8020_0003;

endpackage

// File: rtl/gen_pattern_next.sv
// Combinational successor of the current beat value for the selected pattern mode.
module gen_pattern_next
   import gen_pkg::*;
#(
   parameter int DATA_SIZE = 32
) (
   input  logic [1:0]           mode_i,
   input  logic [DATA_SIZE-1:0] cur_i,
   input  logic [DATA_SIZE-1:0] step_i,
   input  logic [DATA_SIZE-1:0] taps_i,
   output logic [DATA_SIZE-1:0] next_o
);

   always_comb begin
      next_o = cur_i;
      case (mode_e'(mode_i))
         MODE_COUNTER: next_o = cur_i + step_i;
         // Galois form: shift right, fold the dropped bit back through the taps
         MODE_LFSR:    next_o = (cur_i >> 1) ^ (cur_i[0] ? taps_i : '0);
         MODE_CONST:   next_o = cur_i;
         MODE_WALK:    next_o = {cur_i[DATA_SIZE-2:0], cur_i[DATA_SIZE-1]};
         default:      next_o = cur_i;
      endcase
   end

endmodule

// File: rtl/axis_pattern_generator.sv
// AXI4-Stream packet source with counter/LFSR/constant/walking-one patterns.
// Define GEN_PKT_GAP_EN to add the cfg_gap input and idle gaps between packets.
module axis_pattern_generator
   import gen_pkg::*;
#(
   parameter int          DATA_SIZE = 32,
   parameter int          LEN_WIDTH = 16,
   parameter logic [31:0] LFSR_TAPS = LFSR_TAPS_DEFAULT
) (
   input  logic                   m00_axis_aclk,
   input  logic                   m00_axis_aresetn,
   input  logic                   m00_axis_enable,
   input  logic [1:0]             cfg_mode,
   input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
   input  logic [DATA_SIZE-1:0]   cfg_seed,
   input  logic [DATA_SIZE-1:0]   cfg_step,
`ifdef GEN_PKT_GAP_EN
   input  logic [7:0]             cfg_gap,
`endif
   output logic [DATA_SIZE-1:0]   m00_axis_tdata,
   output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
   output logic                   m00_axis_tvalid,
   input  logic                   m00_axis_tready,
   output logic                   m00_axis_tlast,
   output logic                   busy
);

   localparam logic [DATA_SIZE-1:0] TAPS = DATA_SIZE'(LFSR_TAPS);

   state_e                 state_q;
   mode_e                  mode_q;
   logic [LEN_WIDTH-1:0]   last_q;
   logic [LEN_WIDTH-1:0]   beat_q;
   logic [DATA_SIZE-1:0]   step_q;
   logic [DATA_SIZE-1:0]   tdata_q;
   logic                   tvalid_q;
   logic                   tlast_q;
   logic                   busy_q;
`ifdef GEN_PKT_GAP_EN
   logic [7:0]             gap_q;
`endif

   logic                   hs;
   logic                   load_pkt;
   logic                   gap_zero;
   logic [LEN_WIDTH-1:0]   last_d;
   logic [DATA_SIZE-1:0]   tdata_d;

   // Walking-one ignores the seed; an all-zero LFSR seed would lock up, so it becomes 1
   function automatic logic [DATA_SIZE-1:0] first_beat(input mode_e m,
                                                       input logic [DATA_SIZE-1:0] s);
      if (m == MODE_WALK)                return DATA_SIZE'(1);
      if (m == MODE_LFSR && s == '0)     return DATA_SIZE'(1);
      return s;
   endfunction

   assign hs     = tvalid_q & m00_axis_tready;
   assign last_d = (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - LEN_WIDTH'(1);

`ifdef GEN_PKT_GAP_EN
   assign gap_zero = (cfg_gap == 8'd0);
`else
   assign gap_zero = 1'b1;
`endif

   gen_pattern_next #(
      .DATA_SIZE (DATA_SIZE)
   ) u_next (
      .mode_i (mode_q),
      .cur_i  (tdata_q),
      .step_i (step_q),
      .taps_i (TAPS),
      .next_o (tdata_d)
   );

   always_comb begin
      load_pkt = 1'b0;
      case (state_q)
         IDLE:    load_pkt = m00_axis_enable;
         STREAM:  load_pkt = hs && tlast_q && m00_axis_enable && gap_zero;
`ifdef GEN_PKT_GAP_EN
         GAP:     load_pkt = m00_axis_enable && (gap_q == 8'd0);
`endif
         default: load_pkt = 1'b0;
      endcase
   end

   always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
      if (!m00_axis_aresetn) begin
         state_q  <= IDLE;
         mode_q   <= MODE_COUNTER;
         last_q   <= '0;
         beat_q   <= '0;
         step_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef GEN_PKT_GAP_EN
         gap_q    <= '0;
`endif
      end else if (load_pkt) begin
         // Shadow the config so mid-packet changes cannot disturb this packet
         state_q  <= STREAM;
         mode_q   <= mode_e'(cfg_mode);
         last_q   <= last_d;
         step_q   <= cfg_step;
         beat_q   <= '0;
         tdata_q  <= first_beat(mode_e'(cfg_mode), cfg_seed);
         tvalid_q <= 1'b1;
         tlast_q  <= (last_d == '0);
         busy_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: ;
            STREAM: begin
               if (hs) begin
                  if (!tlast_q) begin
                     beat_q  <= beat_q + LEN_WIDTH'(1);
                     tdata_q <= tdata_d;
                     tlast_q <= ((beat_q + LEN_WIDTH'(1)) == last_q);
                  end else begin
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
`ifdef GEN_PKT_GAP_EN
                     if (m00_axis_enable) begin
                        state_q <= GAP;
                        gap_q   <= cfg_gap - 8'd1;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
`else
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
`endif
                  end
               end
            end
`ifdef GEN_PKT_GAP_EN
            GAP: begin
               if (!m00_axis_enable) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  gap_q <= gap_q - 8'd1;
               end
            end
`endif
            default: begin
               state_q  <= IDLE;
               tvalid_q <= 1'b0;
               tlast_q  <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign m00_axis_tdata  = tdata_q;
   assign m00_axis_tstrb  = '1;
   assign m00_axis_tvalid = tvalid_q;
   assign m00_axis_tlast  = tlast_q;
   assign busy            = busy_q;

endmodule
